alu_rev: RTL and testbench

- 32-bit registered integer ALU with "reversed" operand convention.
- For every non-commutative operation, op2 is the left/primary operand and op1 is the right/secondary operand (subtrahend, shift amount, comparison RHS).
- Unary operations act on op1.
- Sits in the execute stage; result and zero flag are registered, one cycle after the inputs are presented.

---
 rtl/alu_rev_pkg.sv | 28 ++
 rtl/alu_rev_shifter.sv | 25 ++
 rtl/alu_rev.sv | 82 ++++++++
 tb/tb_alu_rev.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rev_pkg.sv
// Shared constants for the reversed-operand ALU: opcode map, default width
// and shifter mode encodings.
package alu_rev_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_NOR   = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_BREV  = 4'd11;
  localparam logic [3:0] OP_BSWAP = 4'd12;
  localparam logic [3:0] OP_XNOR  = 4'd13;
  localparam logic [3:0] OP_PASSA = 4'd14;
  localparam logic [3:0] OP_PASSB = 4'd15;

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

endpackage

// File: rtl/alu_rev_shifter.sv
// Combinational barrel shifter: logical left, logical right and arithmetic
// right shift of value by sh.
module alu_rev_shifter
  import alu_rev_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [SHW-1:0]   sh,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] shifted
);

  always_comb begin
    shifted = value;
    case (mode)
      SH_SLL:  shifted = value << sh;
      SH_SRL:  shifted = value >> sh;
      SH_SRA:  shifted = WIDTH'($signed(value) >>> sh);
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/alu_rev.sv
// Registered integer ALU with reversed operands: op2 is the primary (left)
// operand, op1 the secondary operand and the source of unary operations.
module alu_rev
  import alu_rev_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int NBYTES = WIDTH / 8;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] rev_bits;
  logic [WIDTH-1:0] rev_bytes;
  logic [WIDTH-1:0] next_result;
  logic [1:0]       sh_mode;

  always_comb begin
    sh_mode = SH_SLL;
    if (alu_op == OP_SRL) sh_mode = SH_SRL;
    else if (alu_op == OP_SRA) sh_mode = SH_SRA;
  end

  alu_rev_shifter #(.WIDTH(WIDTH)) u_shifter (
    .value   (op2),
    .sh      (op1[SHW-1:0]),
    .mode    (sh_mode),
    .shifted (shifted)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_brev
    assign rev_bits[WIDTH-1-i] = op1[i];
  end

  for (genvar j = 0; j < NBYTES; j++) begin : g_bswap
    assign rev_bytes[(NBYTES-1-j)*8 +: 8] = op1[j*8 +: 8];
  end

  // Every opcode is defined so nothing undriven ever reaches the register
  always_comb begin
    next_result = '0;
    case (alu_op)
      OP_AND:   next_result = op2 & op1;
      OP_OR:    next_result = op2 | op1;
      OP_ADD:   next_result = op2 + op1;
      OP_XOR:   next_result = op2 ^ op1;
      OP_SUB:   next_result = op2 - op1;
      OP_SLT:   next_result = {{(WIDTH-1){1'b0}}, ($signed(op2) < $signed(op1))};
      OP_SLTU:  next_result = {{(WIDTH-1){1'b0}}, (op2 < op1)};
      OP_NOR:   next_result = ~(op2 | op1);
      OP_SLL:   next_result = shifted;
      OP_SRL:   next_result = shifted;
      OP_SRA:   next_result = shifted;
      OP_BREV:  next_result = rev_bits;
      OP_BSWAP: next_result = rev_bytes;
      OP_XNOR:  next_result = ~(op2 ^ op1);
      OP_PASSA: next_result = op2;
      OP_PASSB: next_result = op1;
      default:  next_result = '0;
    endcase
  end

  // zero is derived from the same next value so it always tracks result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b1;
    end else begin
      result <= next_result;
      zero   <= (next_result == '0);
    end
  end

endmodule

// File: tb/tb_alu_rev.sv
// Self-checking bench for alu_rev: directed vectors plus randomized
// back-to-back traffic against an arithmetic reference model.
module tb_alu_rev;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [3:0]   alu_op;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [W-1:0] result;
  logic         zero;

  int tests_run;
  int tests_failed;

  alu_rev #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .alu_op (alu_op),
    .op1    (op1),
    .op2    (op2),
    .result (result),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from plain arithmetic (a = op2, b = op1)
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] a);
    logic [63:0]  wide;
    logic [63:0]  pow2;
    logic [W-1:0] r;
    int           sh;
    int           sa;
    int           sb;
    sh   = int'(b % 32);
    pow2 = 64'd1 << sh;
    sa   = a;
    sb   = b;
    r    = '0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin wide = {32'd0, a} + {32'd0, b}; r = wide[31:0]; end
      4'd3:  r = a ^ b;
      4'd4:  begin wide = {32'd0, a} + 64'h1_0000_0000 - {32'd0, b}; r = wide[31:0]; end
      4'd5:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6:  r = ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      4'd7:  r = ~(a | b);
      4'd8:  begin wide = {32'd0, a} * pow2; r = wide[31:0]; end
      4'd9:  begin wide = {32'd0, a} / pow2; r = wide[31:0]; end
      4'd10: begin
               if (a[31]) begin wide = {32'd0, ~a} / pow2; r = ~wide[31:0]; end
               else begin wide = {32'd0, a} / pow2; r = wide[31:0]; end
             end
      4'd11: for (int i = 0; i < W; i++) r[i] = b[W-1-i];
      4'd12: for (int k = 0; k < 4; k++) r[k*8 +: 8] = b[(3-k)*8 +: 8];
      4'd13: r = ~(a ^ b);
      4'd14: r = a;
      default: r = b;
    endcase
    return r;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [W-1:0] b, input logic [W-1:0] a);
    @(negedge clk);
    alu_op = op;
    op1    = b;
    op2    = a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] exp;
    rst = 1'b1;
    alu_op = 4'd14;
    op1 = 32'h1234_5678;
    op2 = 32'hDEAD_BEEF;
    #1;
    tests_run++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL power_on_reset: result=%h zero=%b, want 0/1", result, zero);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(4'd14, 32'h1234_5678, 32'hDEAD_BEEF);
    tests_run++;
    if (result !== 32'hDEAD_BEEF || zero !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_op: result=%h zero=%b, want deadbeef/0", result, zero);
    end
    // Mid-cycle assert: must clear without a clock edge
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: result=%h zero=%b, want 0/1", result, zero);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold: result=%h zero=%b, want 0/1", result, zero);
    end
    @(negedge clk);
    rst = 1'b0;
    alu_op = 4'd2;
    op1 = 32'd5;
    op2 = 32'd7;
    #1;
    tests_run++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_hold: result=%h zero=%b, want 0/1", result, zero);
    end
    @(posedge clk);
    #1;
    exp = ref_alu(4'd2, 32'd5, 32'd7);
    tests_run++;
    if (result !== exp || zero !== (exp == 0)) begin
      tests_failed++;
      $display("[TB] FAIL first_capture: result=%h zero=%b, want %h", result, zero, exp);
    end
  endtask

  task automatic test_add();
    drive(4'd2, 32'd2647136029, 32'd355320445);
    tests_run++;
    if (result !== 32'd3002456474 || zero !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL add: result=%0d zero=%b, want 3002456474/0", result, zero);
    end
    drive(4'd2, 32'd1, 32'hFFFF_FFFF);
    tests_run++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL add_wrap: result=%h zero=%b, want 0/1", result, zero);
    end
  endtask

  task automatic test_sub_slt();
    drive(4'd4, 32'd1, 32'd0);
    tests_run++;
    if (result !== 32'hFFFF_FFFF || zero !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sub_dir: result=%h zero=%b, want ffffffff/0", result, zero);
    end
    drive(4'd5, 32'd767721039, 32'd1172194643);
    tests_run++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL slt: result=%h zero=%b, want 0/1", result, zero);
    end
    drive(4'd5, 32'd1172194643, 32'd767721039);
    tests_run++;
    if (result !== 32'd1 || zero !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL slt_swap: result=%h zero=%b, want 1/0", result, zero);
    end
    drive(4'd5, 32'd1, 32'hFFFF_FFFF);
    tests_run++;
    if (result !== 32'd1) begin
      tests_failed++;
      $display("[TB] FAIL slt_signed: result=%h, want 1", result);
    end
    drive(4'd6, 32'd1, 32'hFFFF_FFFF);
    tests_run++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sltu_unsigned: result=%h zero=%b, want 0/1", result, zero);
    end
  endtask

  task automatic test_shift();
    drive(4'd10, 32'd2452360430, 32'd3338293616);
    tests_run++;
    if (result !== 32'd4294908905) begin
      tests_failed++;
      $display("[TB] FAIL sra: result=%0d, want 4294908905", result);
    end
    drive(4'd9, 32'd2452360430, 32'd3338293616);
    tests_run++;
    if (result !== 32'd203753) begin
      tests_failed++;
      $display("[TB] FAIL srl: result=%0d, want 203753", result);
    end
    drive(4'd8, 32'hFFFF_FFE1, 32'h8000_0003);
    tests_run++;
    if (result !== 32'h0000_0006) begin
      tests_failed++;
      $display("[TB] FAIL sll_mask: result=%h, want 00000006", result);
    end
    drive(4'd10, 32'd31, 32'h8000_0000);
    tests_run++;
    if (result !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("[TB] FAIL sra_max: result=%h, want ffffffff", result);
    end
  endtask

  task automatic test_unary();
    drive(4'd11, 32'd1, 32'hABCD_0123);
    tests_run++;
    if (result !== 32'h8000_0000) begin
      tests_failed++;
      $display("[TB] FAIL brev: result=%h, want 80000000", result);
    end
    drive(4'd12, 32'h1122_3344, 32'h0);
    tests_run++;
    if (result !== 32'h4433_2211) begin
      tests_failed++;
      $display("[TB] FAIL bswap: result=%h, want 44332211", result);
    end
    drive(4'd15, 32'd0, 32'h5555_AAAA);
    tests_run++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL passb_zero: result=%h zero=%b, want 0/1", result, zero);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   op;
    logic [W-1:0] b;
    logic [W-1:0] a;
    logic [W-1:0] exp;
    for (int rnd = 0; rnd < 20; rnd++) begin
      for (int o = 0; o < 16; o++) begin
        op = 4'(o);
        b  = $urandom;
        a  = $urandom;
        if (rnd % 4 == 1) b = 32'(b % 40);
        if (rnd % 4 == 2) a = b;
        exp = ref_alu(op, b, a);
        drive(op, b, a);
        tests_run++;
        if (result !== exp || zero !== (exp == 32'd0)) begin
          tests_failed++;
          $display("[TB] FAIL b2b_op%0d: a=%h b=%h result=%h zero=%b, want %h/%b",
                   o, a, b, result, zero, exp, (exp == 32'd0));
        end
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst    = 1'b1;
    alu_op = 4'd0;
    op1    = '0;
    op2    = '0;
    test_reset();
    test_add();
    test_sub_slt();
    test_shift();
    test_unary();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
